// File: rtl/cache_axi_bridge_pkg.sv
// Shared encodings for the cache-to-AXI bridge: request types, AXI constants and FSM states.
// Combinational helpers only; no storage, no backpressure.
package cache_axi_bridge_pkg;

    typedef enum logic [2:0] {
        REQ_BYTE = 3'd0,
        REQ_HALF = 3'd1,
        REQ_WORD = 3'd2,
        REQ_LINE = 3'd4
    } req_type_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_ID_INST    = 4'd0;
    localparam logic [3:0] AXI_ID_DATA    = 4'd1;

    typedef enum logic [1:0] {
        R_IDLE,
        R_AR,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_AW,
        W_DATA,
        W_B
    } wr_state_e;

    // A line is four 32-bit beats; everything else is one beat of 2^type[1:0] bytes.
    function automatic logic [7:0] axi_len(input logic [2:0] req_type);
        return (req_type == REQ_LINE) ? 8'd3 : 8'd0;
    endfunction

    function automatic logic [2:0] axi_size(input logic [2:0] req_type);
        return (req_type == REQ_LINE) ? 3'd2 : {1'b0, req_type[1:0]};
    endfunction

endpackage

// File: rtl/cache_axi_bridge_if.sv
// Cache-side request/return signals plus the AXI4 master channels of the bridge.
// master = bridge view, slave = caches + memory interconnect view.
interface cache_axi_bridge_if;

    logic        inst_rd_req;
    logic [2:0]  inst_rd_type;
    logic [31:0] inst_rd_addr;
    logic        inst_rd_rdy;
    logic        inst_ret_valid;
    logic        inst_ret_last;
    logic [31:0] inst_ret_data;

    logic        data_rd_req;
    logic [2:0]  data_rd_type;
    logic [31:0] data_rd_addr;
    logic        data_rd_rdy;
    logic        data_ret_valid;
    logic        data_ret_last;
    logic [31:0] data_ret_data;

    logic        data_wr_req;
    logic [2:0]  data_wr_type;
    logic [31:0] data_wr_addr;
    logic [3:0]  data_wr_wstrb;
    logic [127:0] data_wr_data;
    logic        data_wr_rdy;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        input  inst_rd_req, inst_rd_type, inst_rd_addr,
        output inst_rd_rdy, inst_ret_valid, inst_ret_last, inst_ret_data,
        input  data_rd_req, data_rd_type, data_rd_addr,
        output data_rd_rdy, data_ret_valid, data_ret_last, data_ret_data,
        input  data_wr_req, data_wr_type, data_wr_addr, data_wr_wstrb, data_wr_data,
        output data_wr_rdy,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output inst_rd_req, inst_rd_type, inst_rd_addr,
        input  inst_rd_rdy, inst_ret_valid, inst_ret_last, inst_ret_data,
        output data_rd_req, data_rd_type, data_rd_addr,
        input  data_rd_rdy, data_ret_valid, data_ret_last, data_ret_data,
        output data_wr_req, data_wr_type, data_wr_addr, data_wr_wstrb, data_wr_data,
        input  data_wr_rdy,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/cache_axi_bridge_wr_ch.sv
// Write channel: captures one dcache write, issues AW, streams 1 or 4 W beats, waits for B.
// Accept-to-awvalid 1 cycle; holds every valid until its handshake, refuses new writes until B.
module cache_axi_bridge_wr_ch
    import cache_axi_bridge_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         wr_req_i,
    input  logic [2:0]   wr_type_i,
    input  logic [31:0]  wr_addr_i,
    input  logic [3:0]   wr_wstrb_i,
    input  logic [127:0] wr_data_i,
    output logic         wr_rdy_o,
    output logic         busy_o,
    output logic [27:0]  waddr_tag_o,
    output logic [3:0]   awid_o,
    output logic [31:0]  awaddr_o,
    output logic [7:0]   awlen_o,
    output logic [2:0]   awsize_o,
    output logic [1:0]   awburst_o,
    output logic [1:0]   awlock_o,
    output logic [3:0]   awcache_o,
    output logic [2:0]   awprot_o,
    output logic         awvalid_o,
    input  logic         awready_i,
    output logic [3:0]   wid_o,
    output logic [31:0]  wdata_o,
    output logic [3:0]   wstrb_o,
    output logic         wlast_o,
    output logic         wvalid_o,
    input  logic         wready_i,
    input  logic         bvalid_i,
    output logic         bready_o
);

    wr_state_e    state_q, state_d;
    logic [31:0]  waddr_q, waddr_d;
    logic [2:0]   wtype_q, wtype_d;
    logic [3:0]   wstrb_q, wstrb_d;
    logic [127:0] wline_q, wline_d;
    logic [1:0]   cnt_q, cnt_d;

    assign busy_o      = (state_q != W_IDLE);
    assign waddr_tag_o = waddr_q[31:4];

    assign awid_o    = AXI_ID_DATA;
    assign awaddr_o  = waddr_q;
    assign awlen_o   = axi_len(wtype_q);
    assign awsize_o  = axi_size(wtype_q);
    assign awburst_o = AXI_BURST_INCR;
    assign awlock_o  = 2'b00;
    assign awcache_o = 4'h0;
    assign awprot_o  = 3'h0;
    assign awvalid_o = (state_q == W_AW);

    assign wid_o    = AXI_ID_DATA;
    assign wdata_o  = wline_q[{cnt_q, 5'd0} +: 32];
    assign wstrb_o  = (wtype_q == REQ_LINE) ? 4'hf : wstrb_q;
    assign wvalid_o = (state_q == W_DATA);
    assign wlast_o  = wvalid_o && ({6'd0, cnt_q} == awlen_o);
    assign bready_o = (state_q == W_B);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= W_IDLE;
            waddr_q <= '0;
            wtype_q <= '0;
            wstrb_q <= '0;
            wline_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            wtype_q <= wtype_d;
            wstrb_q <= wstrb_d;
            wline_q <= wline_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        waddr_d  = waddr_q;
        wtype_d  = wtype_q;
        wstrb_d  = wstrb_q;
        wline_d  = wline_q;
        cnt_d    = cnt_q;
        wr_rdy_o = 1'b0;
        case (state_q)
            W_IDLE: begin
                // The cache drops wr_data after this cycle, so the whole line is taken now.
                if (wr_req_i) begin
                    wr_rdy_o = 1'b1;
                    waddr_d  = wr_addr_i;
                    wtype_d  = wr_type_i;
                    wstrb_d  = wr_wstrb_i;
                    wline_d  = wr_data_i;
                    cnt_d    = 2'd0;
                    state_d  = W_AW;
                end
            end
            W_AW: begin
                if (awready_i) state_d = W_DATA;
            end
            W_DATA: begin
                if (wready_i) begin
                    if (wlast_o) begin
                        cnt_d   = 2'd0;
                        state_d = W_B;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            W_B: begin
                if (bvalid_i) state_d = W_IDLE;
            end
            default: state_d = W_IDLE;
        endcase
    end

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache-to-AXI4 bridge: arbitrates icache/dcache reads (dcache first), one read and one write in flight.
// arvalid 1 cycle after accept, return beats pass through with no delay; reads to a line being written wait for B.
module cache_axi_bridge
    import cache_axi_bridge_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    cache_axi_bridge_if.master bus
);

    rd_state_e   rd_state_q, rd_state_d;
    logic        rd_owner_q, rd_owner_d;   // 1 = dcache
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [2:0]  rd_type_q, rd_type_d;

    logic        wr_busy;
    logic [27:0] wr_tag;
    logic        data_ok, inst_ok, in_rdata;
    logic        unused_resp;

    assign unused_resp = ^{bus.rid, bus.rresp, bus.bid, bus.bresp};

    // Compared against the write already outstanding, never the one accepted this cycle.
    assign data_ok = bus.data_rd_req && !(wr_busy && (bus.data_rd_addr[31:4] == wr_tag));
    assign inst_ok = bus.inst_rd_req && !(wr_busy && (bus.inst_rd_addr[31:4] == wr_tag));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_state_q <= R_IDLE;
            rd_owner_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_type_q  <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_owner_q <= rd_owner_d;
            rd_addr_q  <= rd_addr_d;
            rd_type_q  <= rd_type_d;
        end
    end

    always_comb begin
        rd_state_d      = rd_state_q;
        rd_owner_d      = rd_owner_q;
        rd_addr_d       = rd_addr_q;
        rd_type_d       = rd_type_q;
        bus.inst_rd_rdy = 1'b0;
        bus.data_rd_rdy = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (data_ok) begin
                    bus.data_rd_rdy = 1'b1;
                    rd_owner_d      = 1'b1;
                    rd_addr_d       = bus.data_rd_addr;
                    rd_type_d       = bus.data_rd_type;
                    rd_state_d      = R_AR;
                end else if (inst_ok) begin
                    bus.inst_rd_rdy = 1'b1;
                    rd_owner_d      = 1'b0;
                    rd_addr_d       = bus.inst_rd_addr;
                    rd_type_d       = bus.inst_rd_type;
                    rd_state_d      = R_AR;
                end
            end
            R_AR: begin
                if (bus.arready) rd_state_d = R_DATA;
            end
            R_DATA: begin
                if (bus.rvalid && bus.rlast) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    assign bus.arid    = rd_owner_q ? AXI_ID_DATA : AXI_ID_INST;
    assign bus.araddr  = rd_addr_q;
    assign bus.arlen   = axi_len(rd_type_q);
    assign bus.arsize  = axi_size(rd_type_q);
    assign bus.arburst = AXI_BURST_INCR;
    assign bus.arlock  = 2'b00;
    assign bus.arcache = 4'h0;
    assign bus.arprot  = 3'h0;
    assign bus.arvalid = (rd_state_q == R_AR);

    assign in_rdata           = (rd_state_q == R_DATA);
    assign bus.rready         = in_rdata;
    assign bus.data_ret_valid = in_rdata &&  rd_owner_q && bus.rvalid;
    assign bus.data_ret_last  = in_rdata &&  rd_owner_q && bus.rlast;
    assign bus.inst_ret_valid = in_rdata && !rd_owner_q && bus.rvalid;
    assign bus.inst_ret_last  = in_rdata && !rd_owner_q && bus.rlast;
    assign bus.data_ret_data  = in_rdata ? bus.rdata : 32'h0;
    assign bus.inst_ret_data  = in_rdata ? bus.rdata : 32'h0;

    cache_axi_bridge_wr_ch u_wr_ch (
        .clk         (clk),
        .resetn      (resetn),
        .wr_req_i    (bus.data_wr_req),
        .wr_type_i   (bus.data_wr_type),
        .wr_addr_i   (bus.data_wr_addr),
        .wr_wstrb_i  (bus.data_wr_wstrb),
        .wr_data_i   (bus.data_wr_data),
        .wr_rdy_o    (bus.data_wr_rdy),
        .busy_o      (wr_busy),
        .waddr_tag_o (wr_tag),
        .awid_o      (bus.awid),
        .awaddr_o    (bus.awaddr),
        .awlen_o     (bus.awlen),
        .awsize_o    (bus.awsize),
        .awburst_o   (bus.awburst),
        .awlock_o    (bus.awlock),
        .awcache_o   (bus.awcache),
        .awprot_o    (bus.awprot),
        .awvalid_o   (bus.awvalid),
        .awready_i   (bus.awready),
        .wid_o       (bus.wid),
        .wdata_o     (bus.wdata),
        .wstrb_o     (bus.wstrb),
        .wlast_o     (bus.wlast),
        .wvalid_o    (bus.wvalid),
        .wready_i    (bus.wready),
        .bvalid_i    (bus.bvalid),
        .bready_o    (bus.bready)
    );

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: reads, arbitration, line/uncached writes, hazard hold, mid-burst reset.
module tb_cache_axi_bridge;

    logic clk = 1'b0;
    logic resetn;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cache_axi_bridge_if bus();

    cache_axi_bridge dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic serve_ar(input string tag, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [31:0] addr);
        int k = 0;
        while (!bus.arvalid && k < 20) begin
            tick();
            k++;
        end
        check_eq($sformatf("%s_arvalid", tag), 128'(bus.arvalid), 128'd1);
        check_eq($sformatf("%s_ar", tag),
                 {bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.arlock, bus.arcache, bus.arprot},
                 {id, addr, len, size, 2'b01, 9'd0});
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
    endtask

    task automatic serve_r(input string tag, input bit is_data, input int n, input logic [31:0] base);
        logic [31:0] d;
        logic        last;
        for (int i = 0; i < n; i++) begin
            d          = base + 32'(i);
            last       = (i == n - 1);
            bus.rvalid = 1'b1;
            bus.rdata  = d;
            bus.rlast  = last;
            settle();
            check_eq($sformatf("%s_beat%0d", tag, i),
                     {bus.rready, bus.inst_ret_valid, bus.inst_ret_last, bus.data_ret_valid, bus.data_ret_last,
                      bus.inst_ret_data, bus.data_ret_data},
                     is_data ? {1'b1, 1'b0, 1'b0, 1'b1, last, d, d} : {1'b1, 1'b1, last, 1'b0, 1'b0, d, d});
            tick();
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rdata  = '0;
    endtask

    logic [31:0] lw_words [4];
    int beat;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        lw_words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        resetn = 1'b0;
        bus.inst_rd_req = 0; bus.inst_rd_type = 0; bus.inst_rd_addr = 0;
        bus.data_rd_req = 0; bus.data_rd_type = 0; bus.data_rd_addr = 0;
        bus.data_wr_req = 0; bus.data_wr_type = 0; bus.data_wr_addr = 0;
        bus.data_wr_wstrb = 0; bus.data_wr_data = 0;
        bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0; bus.rvalid = 0;
        bus.awready = 0; bus.wready = 0; bus.bid = 0; bus.bresp = 0; bus.bvalid = 0;

        // Reset state
        tick();
        tick();
        check_eq("reset_valids",
                 {bus.arvalid, bus.awvalid, bus.wvalid, bus.wlast, bus.rready, bus.bready,
                  bus.inst_ret_valid, bus.inst_ret_last, bus.data_ret_valid, bus.data_ret_last,
                  bus.inst_rd_rdy, bus.data_rd_rdy, bus.data_wr_rdy}, 128'd0);
        check_eq("reset_regs", {bus.araddr, bus.awaddr, bus.arlen, bus.awlen, bus.wdata, bus.wstrb}, 128'd0);
        resetn = 1'b1;
        tick();

        // Data line read
        bus.data_rd_req = 1; bus.data_rd_type = 3'd4; bus.data_rd_addr = 32'h1C00_0040;
        settle();
        check_eq("lr_rdy", {bus.data_rd_rdy, bus.inst_rd_rdy, bus.arvalid}, 3'b100);
        tick();
        bus.data_rd_req = 0;
        serve_ar("lr", 4'd1, 8'd3, 3'd2, 32'h1C00_0040);
        serve_r("lr", 1'b1, 4, 32'hD000_0000);

        // Same-cycle inst and data reads: data first, inst after rlast
        bus.data_rd_req = 1; bus.data_rd_type = 3'd2; bus.data_rd_addr = 32'h0000_0200;
        bus.inst_rd_req = 1; bus.inst_rd_type = 3'd2; bus.inst_rd_addr = 32'h0000_0100;
        settle();
        check_eq("arb_grant", {bus.data_rd_rdy, bus.inst_rd_rdy}, 2'b10);
        tick();
        bus.data_rd_req = 0;
        settle();
        check_eq("arb_inst_wait", 128'(bus.inst_rd_rdy), 128'd0);
        serve_ar("arb_d", 4'd1, 8'd0, 3'd2, 32'h0000_0200);
        serve_r("arb_d", 1'b1, 1, 32'hA000_0000);
        settle();
        check_eq("arb_inst_grant", {bus.inst_rd_rdy, bus.data_rd_rdy}, 2'b10);
        tick();
        bus.inst_rd_req = 0;
        serve_ar("arb_i", 4'd0, 8'd0, 3'd2, 32'h0000_0100);
        serve_r("arb_i", 1'b0, 1, 32'hB000_0000);

        // Line write with toggling wready, plus a read hazard on the same line
        bus.data_wr_req = 1; bus.data_wr_type = 3'd4; bus.data_wr_addr = 32'h0000_1230;
        bus.data_wr_wstrb = 4'h0;
        bus.data_wr_data = {lw_words[3], lw_words[2], lw_words[1], lw_words[0]};
        settle();
        check_eq("lw_rdy", 128'(bus.data_wr_rdy), 128'd1);
        tick();
        bus.data_wr_req = 0; bus.data_wr_data = '0;
        bus.data_rd_req = 1; bus.data_rd_type = 3'd2; bus.data_rd_addr = 32'h0000_1238;
        settle();
        check_eq("lw_aw",
                 {bus.awvalid, bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst, bus.awlock, bus.awcache, bus.awprot},
                 {1'b1, 4'd1, 32'h0000_1230, 8'd3, 3'd2, 2'b01, 9'd0});
        check_eq("hz_aw", 128'(bus.data_rd_rdy), 128'd0);
        bus.awready = 1;
        tick();
        bus.awready = 0;
        beat = 0;
        for (int k = 0; k < 40 && beat < 4; k++) begin
            bus.wready = k[0];
            settle();
            if (bus.wvalid && bus.wready) begin
                check_eq($sformatf("lw_beat%0d", beat), {bus.wdata, bus.wstrb, bus.wlast, bus.wid},
                         {lw_words[beat], 4'hf, 1'(beat == 3), 4'd1});
                beat++;
            end
            tick();
        end
        bus.wready = 0;
        check_eq("lw_beats", 128'(beat), 128'd4);
        settle();
        check_eq("hz_wb", {bus.bready, bus.data_rd_rdy, bus.wvalid}, 3'b100);
        tick();
        bus.bvalid = 1;
        settle();
        check_eq("hz_bvalid", {bus.bready, bus.data_rd_rdy}, 2'b10);
        tick();
        bus.bvalid = 0;
        settle();
        check_eq("hz_release", {bus.bready, bus.data_rd_rdy, bus.awvalid}, 3'b010);
        tick();
        bus.data_rd_req = 0;
        serve_ar("hz", 4'd1, 8'd0, 3'd2, 32'h0000_1238);
        serve_r("hz", 1'b1, 1, 32'hC000_0000);

        // Uncached byte read by the icache
        bus.inst_rd_req = 1; bus.inst_rd_type = 3'd0; bus.inst_rd_addr = 32'hBFAF_8003;
        settle();
        check_eq("ub_rdy", 128'(bus.inst_rd_rdy), 128'd1);
        tick();
        bus.inst_rd_req = 0;
        serve_ar("ub", 4'd0, 8'd0, 3'd0, 32'hBFAF_8003);
        serve_r("ub", 1'b0, 1, 32'h0000_00EF);

        // Uncached byte write
        bus.data_wr_req = 1; bus.data_wr_type = 3'd0; bus.data_wr_addr = 32'h0000_2002;
        bus.data_wr_wstrb = 4'b0100; bus.data_wr_data = 128'h0000_0000_0000_0000_0000_0000_00AB_0000;
        settle();
        check_eq("uw_rdy", 128'(bus.data_wr_rdy), 128'd1);
        tick();
        bus.data_wr_req = 0;
        settle();
        check_eq("uw_aw", {bus.awvalid, bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst},
                 {1'b1, 4'd1, 32'h0000_2002, 8'd0, 3'd0, 2'b01});
        bus.awready = 1;
        tick();
        bus.awready = 0;
        bus.wready = 1;
        settle();
        check_eq("uw_w", {bus.wvalid, bus.wdata, bus.wstrb, bus.wlast}, {1'b1, 32'h00AB_0000, 4'b0100, 1'b1});
        tick();
        bus.wready = 0;
        settle();
        check_eq("uw_b", {bus.bready, bus.wvalid}, 2'b10);
        bus.bvalid = 1;
        tick();
        bus.bvalid = 0;
        settle();
        check_eq("uw_done", 128'(bus.bready), 128'd0);

        // Reset in the middle of W_DATA and R_DATA
        bus.data_wr_req = 1; bus.data_wr_type = 3'd4; bus.data_wr_addr = 32'h0000_3000;
        bus.data_wr_data = 128'h5555_5555_6666_6666_7777_7777_8888_8888;
        bus.data_rd_req = 1; bus.data_rd_type = 3'd4; bus.data_rd_addr = 32'h0000_5000;
        settle();
        check_eq("rst_accept", {bus.data_wr_rdy, bus.data_rd_rdy}, 2'b11);
        tick();
        bus.data_wr_req = 0; bus.data_rd_req = 0;
        bus.awready = 1; bus.arready = 1;
        tick();
        bus.awready = 0; bus.arready = 0;
        bus.wready = 1; bus.rvalid = 1; bus.rdata = 32'h1234_5678;
        settle();
        check_eq("rst_mid", {bus.wvalid, bus.rready, bus.data_ret_valid, bus.wdata}, {3'b111, 32'h8888_8888});
        tick();
        bus.wready = 0; bus.rvalid = 0; bus.rdata = 0;
        resetn = 0;
        tick();
        check_eq("rst_outs",
                 {bus.arvalid, bus.awvalid, bus.wvalid, bus.wlast, bus.rready, bus.bready,
                  bus.inst_ret_valid, bus.data_ret_valid, bus.data_ret_last, bus.wstrb}, 128'd0);
        resetn = 1;
        bus.data_rd_req = 1; bus.data_rd_type = 3'd2; bus.data_rd_addr = 32'h0000_3004;
        settle();
        check_eq("rst_new_rdy", 128'(bus.data_rd_rdy), 128'd1);
        tick();
        bus.data_rd_req = 0;
        serve_ar("rst_rd", 4'd1, 8'd0, 3'd2, 32'h0000_3004);
        serve_r("rst_rd", 1'b1, 1, 32'hE000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
